// File: rtl/register_file_8x32_if.sv
// Register file bus interface.
// Groups the write port, both read ports and the bulk-clear handshake.
//   master : drives wr_en/wr_addr/wr_data, rd_addr0/1, clr_req;
//            receives rd_data0/1, busy, clr_done.
//   slave  : the register file side (opposite directions).
interface register_file_8x32_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr0;
    logic [DATA_W-1:0] rd_data0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] rd_data1;
    logic              clr_req;
    logic              busy;
    logic              clr_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr0, rd_addr1, clr_req,
        input  rd_data0, rd_data1, busy, clr_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr0, rd_addr1, clr_req,
        output rd_data0, rd_data1, busy, clr_done
    );
endinterface

// File: rtl/register_file_8x32.sv
// Eight-entry, 32-bit register file: one synchronous write port, two
// combinational read ports, and a bulk-clear engine that zeroes one entry
// per cycle (IDLE -> CLEAR x NUM_REGS -> DONE -> IDLE).
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset (all entries, FSM, pointer)
//   bus      : register_file_8x32_if.slave (write, reads, clr_req/busy/clr_done)
// Optional: define RF_BYPASS_EN for same-cycle write-through forwarding
// on each read port.
module register_file_8x32 #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8   // must equal 2**ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    register_file_8x32_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic [NUM_REGS-1:0] reg_en;
    logic [DATA_W-1:0]   reg_wdata;
    logic                busy;
    logic                host_wr;

    assign busy    = (state_q == CLEAR);
    assign host_wr = bus.wr_en && !busy;

    // Next-state logic for the clear sequencer
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Per-entry enable decode: the sweep owns the array while busy, so host
    // writes are simply not decoded then (dropped, not queued).
    always_comb begin
        reg_en    = '0;
        reg_wdata = bus.wr_data;
        if (busy) begin
            reg_en[ptr_q] = 1'b1;
            reg_wdata     = '0;
        end else if (bus.wr_en) begin
            reg_en[bus.wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < unsigned'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < unsigned'(NUM_REGS); i++) begin
                if (reg_en[i]) begin
                    regs_q[i] <= reg_wdata;
                end
            end
        end
    end

`ifdef RF_BYPASS_EN
    // Forward only host writes; sweep zeros are never bypassed.
    assign bus.rd_data0 = (host_wr && (bus.wr_addr == bus.rd_addr0)) ?
                          bus.wr_data : regs_q[bus.rd_addr0];
    assign bus.rd_data1 = (host_wr && (bus.wr_addr == bus.rd_addr1)) ?
                          bus.wr_data : regs_q[bus.rd_addr1];
`else
    logic unused_host_wr;
    assign unused_host_wr = host_wr;
    assign bus.rd_data0   = regs_q[bus.rd_addr0];
    assign bus.rd_data1   = regs_q[bus.rd_addr1];
`endif

    assign bus.busy     = busy;
    assign bus.clr_done = (state_q == DONE);

endmodule

// File: tb/tb_register_file_8x32.sv
// Self-checking bench for register_file_8x32: expected values come from a
// bench-side model and are queued, then popped when the DUT output is read.
module tb_register_file_8x32;

    logic clk;
    logic reset_n;

    register_file_8x32_if #(.DATA_W(32), .ADDR_W(3)) rf_if ();

    register_file_8x32 #(.DATA_W(32), .ADDR_W(3), .NUM_REGS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [8];
    int          checks = 0;
    int          errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        exp_t e;
        if (sbq.size() == 0) begin
            check_eq("sb_underflow", got, ~got);
        end else begin
            e = sbq.pop_front();
            check_eq(e.tag, got, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read both ports; expectations taken from the model when driven.
    task automatic rd2(input int a0, input int a1, input string tag);
        rf_if.rd_addr0 = 3'(a0);
        rf_if.rd_addr1 = 3'(a1);
        sb_push($sformatf("%s_p0[%0d]", tag, a0), model[a0]);
        sb_push($sformatf("%s_p1[%0d]", tag, a1), model[a1]);
        #1;
        sb_pop(rf_if.rd_data0);
        sb_pop(rf_if.rd_data1);
    endtask

    task automatic stat(input string tag, input logic eb, input logic ed);
        sb_push({tag, "_busy"}, {31'b0, eb});
        sb_push({tag, "_done"}, {31'b0, ed});
        sb_pop({31'b0, rf_if.busy});
        sb_pop({31'b0, rf_if.clr_done});
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        rf_if.wr_en   = 1'b1;
        rf_if.wr_addr = 3'(a);
        rf_if.wr_data = d;
        tick();
        rf_if.wr_en   = 1'b0;
        model[a]      = d;
    endtask

    task automatic rd_all(input string tag);
        for (int i = 0; i < 8; i += 2) rd2(i, i + 1, tag);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = '0;
        rf_if.wr_en    = 1'b0;
        rf_if.wr_addr  = '0;
        rf_if.wr_data  = '0;
        rf_if.rd_addr0 = '0;
        rf_if.rd_addr1 = '0;
        rf_if.clr_req  = 1'b0;

        // Reset then basic writes
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        stat("reset", 1'b0, 1'b0);
        rd2(0, 5, "reset");
        tick();
        wr(1, 32'haabbccdd);
        wr(2, 32'h11223344);
        wr(7, 32'h99887766);
        rd2(1, 7, "write");
        rd2(0, 3, "untouched");

        // Dual read of one entry, before and after an overwrite
        rd2(2, 2, "same_addr");
        wr(2, 32'habcdef12);
        rd2(2, 2, "same_addr_new");

        // Full sweep with a dropped mid-sweep write and a DONE-cycle write
        for (int i = 0; i < 8; i++) wr(i, 32'h01010101 * (i + 1) + 32'h10);
        rf_if.clr_req = 1'b1;
        tick();
        rf_if.clr_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            stat($sformatf("sweep%0d", k), 1'b1, 1'b0);
            if (k == 6) begin
                rf_if.wr_en   = 1'b1;
                rf_if.wr_addr = 3'd5;
                rf_if.wr_data = 32'h11883366;
                rd2(5, 5, "busy_no_bypass");
            end
            tick();
            rf_if.wr_en = 1'b0;
            model[k]    = '0;
            rd2(k, (k + 1) % 8, $sformatf("sweep%0d", k));
        end
        stat("done", 1'b0, 1'b1);
        rd_all("done_zero");
        wr(4, 32'h44440004);
        stat("after_done", 1'b0, 1'b0);
        rd2(4, 5, "done_write");

        // Write and clr_req on the same IDLE edge
        rf_if.clr_req = 1'b1;
        wr(0, 32'h12345678);
        rf_if.clr_req = 1'b0;
        stat("simul", 1'b1, 1'b0);
        rd2(0, 0, "simul_kept");
        for (int k = 0; k < 8; k++) begin
            tick();
            model[k] = '0;
        end
        rd_all("simul_clear");
        tick();
        stat("simul_idle", 1'b0, 1'b0);

        // clr_req held high: 8 CLEAR, 1 DONE, 1 IDLE, repeat
        rf_if.clr_req = 1'b1;
        tick();
        for (int c = 0; c < 20; c++) begin
            stat($sformatf("b2b%0d", c), (c % 10) < 8, (c % 10) == 8);
            if (c == 19) rf_if.clr_req = 1'b0;
            tick();
        end
        stat("b2b_end", 1'b0, 1'b0);

        // Async reset on the 4th CLEAR cycle, off the clock edge
        wr(3, 32'h33333333);
        wr(7, 32'h77777777);
        rf_if.clr_req = 1'b1;
        tick();
        rf_if.clr_req = 1'b0;
        tick();
        tick();
        tick();
        stat("pre_reset", 1'b1, 1'b0);
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = '0;
        rd2(3, 7, "async_rst");
        rd2(0, 4, "async_rst");
        stat("async_rst", 1'b0, 1'b0);
        reset_n = 1'b1;
        rf_if.wr_en    = 1'b1;
        rf_if.wr_addr  = 3'd3;
        rf_if.wr_data  = 32'hdeadbeef;
        rf_if.rd_addr0 = 3'd3;
        rf_if.rd_addr1 = 3'd4;
`ifdef RF_BYPASS_EN
        sb_push("bypass_p0", 32'hdeadbeef);
`else
        sb_push("bypass_p0", 32'h0);
`endif
        sb_push("bypass_p1", 32'h0);
        #1;
        sb_pop(rf_if.rd_data0);
        sb_pop(rf_if.rd_data1);
        tick();
        rf_if.wr_en = 1'b0;
        model[3]    = 32'hdeadbeef;
        rd2(3, 4, "post_rst_write");
        tick();
        stat("post_rst_idle", 1'b0, 1'b0);

        check_eq("sb_drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
